// File: rtl/hazard_ctrl_if.sv
// Bundle of ID-stage hazard inputs and hazard-control outputs shared between
// the decode stage (master) and hazard_ctrl (slave).
interface hazard_ctrl_if;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_wreg;
  logic        id_m2reg;
  logic [4:0]  id_rn;
  logic [1:0]  pcsource;
  logic        stall;
  logic        flush;
  logic [1:0]  fwda;
  logic [1:0]  fwdb;
  logic [15:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_wreg, id_m2reg, id_rn, pcsource,
    input  stall, flush, fwda, fwdb, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_wreg, id_m2reg, id_rn, pcsource,
    output stall, flush, fwda, fwdb, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: stall / flush / operand forwarding for a 5-stage pipe.
// Define HAZARD_CTRL_FORWARD_EN for bypassing; otherwise dependencies stall until writeback.
module hazard_ctrl (
  input  logic         clk,
  input  logic         clrn,
  hazard_ctrl_if.slave hz
);

  typedef struct packed {
    logic       valid;
    logic       wreg;
    logic       m2reg;
    logic [4:0] rn;
  } stage_t;

  stage_t      ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stall;
  logic [1:0]  fwda, fwdb;
  logic        ex_rs, mem_rs, wb_rs, ex_rt, mem_rt, wb_rt;

  // Register 0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic hits(stage_t s, logic [4:0] r, logic use_r, logic id_v);
    return id_v & use_r & s.valid & s.wreg & (s.rn != 5'd0) & (s.rn == r);
  endfunction

  always_comb begin
    ex_rs  = hits(ex_q,  hz.id_rs, hz.id_use_rs, hz.id_valid);
    mem_rs = hits(mem_q, hz.id_rs, hz.id_use_rs, hz.id_valid);
    wb_rs  = hits(wb_q,  hz.id_rs, hz.id_use_rs, hz.id_valid);
    ex_rt  = hits(ex_q,  hz.id_rt, hz.id_use_rt, hz.id_valid);
    mem_rt = hits(mem_q, hz.id_rt, hz.id_use_rt, hz.id_valid);
    wb_rt  = hits(wb_q,  hz.id_rt, hz.id_use_rt, hz.id_valid);
  end

  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    stall = 1'b0;
    fwda  = 2'b00;
    fwdb  = 2'b00;
`ifdef HAZARD_CTRL_FORWARD_EN
    // Only a load in EX cannot be bypassed: its data is not ready until MEM.
    stall = (ex_rs | ex_rt) & ex_q.m2reg;
    if (!stall) begin
      if (ex_rs && !ex_q.m2reg) fwda = 2'b01;
      else if (mem_rs)          fwda = 2'b10;
      else if (wb_rs)           fwda = 2'b11;
      if (ex_rt && !ex_q.m2reg) fwdb = 2'b01;
      else if (mem_rt)          fwdb = 2'b10;
      else if (wb_rt)           fwdb = 2'b11;
    end
`else
    stall = ex_rs | ex_rt | mem_rs | mem_rt | wb_rs | wb_rt;
`endif
  end

  always_comb begin
    ex_d.valid  = hz.id_valid & ~stall;
    ex_d.wreg   = hz.id_wreg;
    ex_d.m2reg  = hz.id_m2reg;
    ex_d.rn     = hz.id_rn;
    mem_d       = ex_q;
    wb_d        = mem_q;
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all stages shift together.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.stall     = stall;
  assign hz.flush     = hz.id_valid & (hz.pcsource != 2'b00) & ~stall;
  assign hz.fwda      = fwda;
  assign hz.fwdb      = fwdb;
  assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock, sole clock.
REQ-002 SHALL have ports: clrn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: id_valid  in  1  ID holds a real instruction; id_rs, id_rt  in  5  ID source register numbers.
REQ-004 SHALL have ports: id_use_rs, id_use_rt  in  1  ID instruction reads rs / rt.
REQ-005 SHALL have ports: id_wreg, id_m2reg  in  1  ID instruction writes a register / is a load; id_rn  in  5  ID destination.
REQ-006 SHALL have ports: pcsource  in  2  ID next-PC select (00 sequential, 01 branch taken, 10 register jump, 11 jump).
REQ-007 SHALL have ports: stall  out  1  hold PC and IF/ID, insert bubble into EX; flush  out  1  discard instruction currently in IF.
REQ-008 SHALL have ports: fwda, fwdb  out  2  operand source for a/b (00 regfile, 01 EX ALU result, 10 MEM result, 11 WB write data wdi).
REQ-009 SHALL have ports: stall_cnt  out  16  count of stall cycles since reset.

Function
REQ-010 SHALL keep three stage records EX, MEM, WB, each {valid, wreg, m2reg, rn[4:0]}, advancing every rising clk edge.
REQ-011 SHALL load EX from {id_valid, id_wreg, id_m2reg, id_rn} when stall=0, and with valid=0 (bubble) when stall=1; MEM<=EX and WB<=MEM unconditionally.
REQ-012 SHALL define "stage X hits rs" as X.valid & X.wreg & X.rn!=0 & X.rn==id_rs & id_use_rs & id_valid; same for rt; register 0 never hits.
REQ-013 SHALL, with forwarding, assert stall combinationally when EX hits rs or rt and EX.m2reg=1 (load-use); exactly one stall cycle per load-use.
REQ-014 SHALL set fwda by priority EX (01, only if EX.m2reg=0) > MEM (10) > WB (11) > regfile (00); fwdb identically for rt.
REQ-015 SHALL drive fwda/fwdb to 00 whenever stall=1.
REQ-016 SHALL assert flush = id_valid & (pcsource!=00) & ~stall; flush lasts one cycle per control-transfer instruction.
REQ-017 SHALL suppress flush while stall=1 (branch operands unresolved); flush asserts in the first non-stall cycle.
REQ-018 SHALL increment stall_cnt by 1 on each rising edge where stall=1, saturating at 16'hFFFF (no wrap).
REQ-019 SHALL not stall or forward when id_valid=0, irrespective of EX/MEM/WB contents.
REQ-020 SHALL be purely combinational from inputs and stage records to stall, flush, fwda, fwdb (zero latency).

Reset
REQ-021 SHALL, while clrn=0, clear all stage records (valid=0, wreg=0, m2reg=0, rn=0) and stall_cnt=0 immediately, independent of clk.
REQ-022 SHALL hold stall=0, flush=0, fwda=00, fwdb=00 during and immediately after reset with id_valid=0.
REQ-023 SHALL, on reset mid-stall, drop the pending hazard; the first post-reset instruction sees no hits.

Configuration
REQ-024 SHALL honour macro HAZARD_CTRL_FORWARD_EN: defined -> REQ-013..REQ-015 behaviour.
REQ-025 SHALL, with HAZARD_CTRL_FORWARD_EN undefined, tie fwda=fwdb=00 and assert stall whenever any of EX, MEM, WB hits rs or rt (load or not); worst case three stall cycles per dependency.

Verification
REQ-026 SHALL pass: ALU op writes r5, next ID reads rs=5 -> fwda=01, stall=0; one cycle later fwda=10; then 11; then 00.
REQ-027 SHALL pass: load to r7, next ID reads rt=7 -> stall=1 one cycle, EX bubble, then fwdb=10, stall_cnt=1.
REQ-028 SHALL pass: instruction writes r0, next ID reads rs=0 -> fwda=00, stall=0.
REQ-029 SHALL pass: load r3 followed by branch using r3 with pcsource=01 -> stall=1 and flush=0 in cycle 1, flush=1 in cycle 2.
REQ-030 SHALL pass: clrn pulsed low during a load-use stall -> stall=0, stall_cnt=0, all records invalid within same cycle.
REQ-031 SHALL pass (HAZARD_CTRL_FORWARD_EN undefined): ALU op writes r9, next ID reads r9 -> stall=1 for 3 cycles, fwda=00, stall_cnt=3.
